serial_sub: RTL and testbench

//   Bit-serial subtractor: computes diff = a - b - bin over WIDTH bits, LSB first,
//   one bit per clock, using a single full-subtractor cell plus a registered borrow.

---
 rtl/serial_sub.sv | 118 +++++++++++
 tb/tb_serial_sub.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor, LSB first, one full-subtractor cell plus registered borrow

module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    count_q, count_d;

    logic cell_d, cell_bo, last_bit;

    serial_sub_cell u_cell (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign last_bit = (state_q == RUN) && (count_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result fills from the MSB end so after WIDTH shifts bit 0 holds the first difference bit.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        count_d = count_q;
        if (state_q == IDLE && start) begin
            a_d     = a_in;
            b_d     = b_in;
            brw_d   = bin;
            count_d = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
            brw_d   = cell_bo;
            count_d = count_q + CW'(1);
            if (last_bit) begin
                diff_d = res_d;
                bout_d = cell_bo;
            end
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        diff = diff_q;
        bout = bout_q;
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub at WIDTH=1 and WIDTH=8

module tb_serial_sub;
    logic       clk = 1'b0;
    logic       rst;
    logic       s1, a1, b1, bi1;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;
    logic       s8, bi8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;
    int         tests = 0;
    int         fails = 0;

    serial_sub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1), .a_in(a1), .b_in(b1), .bin(bi1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .a_in(a8), .b_in(b8), .bin(bi8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction; borrow is simply "result went negative".
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bn, input logic hold);
        int         r;
        logic [7:0] ed;
        logic       eb;
        r  = int'(a) - int'(b) - int'(bn);
        ed = r[7:0];
        eb = (r < 0);
        a8 = a; b8 = b; bi8 = bn; s8 = 1'b1;
        step;
        if (!hold) s8 = 1'b0;
        a8  = 8'($urandom_range(255));
        b8  = 8'($urandom_range(255));
        bi8 = 1'($urandom_range(1));
        chk("op8_run_first", {busy8, done8}, 2'b10);
        for (int k = 1; k < 8; k++) begin
            step;
            chk("op8_run", {busy8, done8}, 2'b10);
        end
        step;
        chk("op8_done", {busy8, done8}, 2'b11);
        chk("op8_diff", diff8, ed);
        chk("op8_bout", bout8, eb);
        step;
        chk("op8_idle", {busy8, done8}, 2'b00);
        chk("op8_hold_result", {bout8, diff8}, {eb, ed});
    endtask

    task automatic op1(input logic a, input logic b, input logic bn);
        int   r;
        logic ed, eb;
        r  = int'(a) - int'(b) - int'(bn);
        ed = r[0];
        eb = (r < 0);
        a1 = a; b1 = b; bi1 = bn; s1 = 1'b1;
        step;
        s1 = 1'b0; a1 = ~a; b1 = ~b; bi1 = ~bn;
        chk("op1_run", {busy1, done1}, 2'b10);
        step;
        chk("op1_done", {busy1, done1}, 2'b11);
        chk("op1_result", {bout1, diff1}, {eb, ed});
        step;
        chk("op1_idle", {busy1, done1}, 2'b00);
    endtask

    initial begin
        logic seen_done;
        rst = 1'b1;
        s1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
        s8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bi8 = 1'b0;
        step;
        step;
        chk("reset_w8", {busy8, done8, bout8, diff8}, 32'h0);
        chk("reset_w1", {busy1, done1, bout1, diff1}, 32'h0);
        rst = 1'b0;
        step;

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0]);
        end

        op8(8'h35, 8'h12, 1'b0, 1'b0);
        op8(8'h10, 8'h0F, 1'b1, 1'b0);
        op8(8'h00, 8'h01, 1'b0, 1'b0);

        // start held high while operands churn; the second op must wait for IDLE
        op8(8'h77, 8'h33, 1'b0, 1'b1);
        op8(8'h0A, 8'h0B, 1'b0, 1'b0);

        a8 = 8'h5A; b8 = 8'h21; bi8 = 1'b0; s8 = 1'b1;
        step;
        s8 = 1'b0;
        step;
        step;
        step;
        rst = 1'b1;
        step;
        chk("rst_mid_run", {busy8, done8, bout8, diff8}, 32'h0);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step;
            if (done8) seen_done = 1'b1;
        end
        chk("rst_no_done", {seen_done, busy8}, 2'b00);
        op8(8'h5A, 8'h21, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            op8(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
